pingpong_bank_ctrl: RTL
=======================

# pingpong_bank_ctrl

- Bank manager for the two-bank ping-pong frame buffer between the FFT output stream and the ping-pong-to-AXI4 reader.
- Accepts an AXI4-Stream frame and writes it into whichever bank is free through port A.
- Hands completed banks to the reader in fill order using the `readyb`/`finishb` handshake, and reclaims each bank when the reader finishes.
- Prevents the writer and reader from ever owning the same bank.

## Interface
Parameters:
- `ADDRBITS`, 7: per-bank address width.
- `DATABITS`, 16: sample width.
- `MEMDEPTH`, 128: words per frame/bank; must be ≤ 2^ADDRBITS and ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous reset, active-low (0 = reset).
- `s_axis_data_tdata`  in  DATABITS: input sample.
- `s_axis_data_tvalid`  in  1: input valid.
- `s_axis_data_tready`  out  1: input ready.
- `s_axis_data_tlast`  in  1: end of input frame.
- `addra`  out  ADDRBITS: port-A write address.
- `dina`  out  DATABITS: port-A write data.
- `wea`  out  1: port-A write enable.
- `banka`  out  1: bank being written; forms the port-A address MSB.
- `bankb`  out  1: bank the reader must read; forms the port-B address MSB.
- `readyb`  out  1: `bankb` holds a full frame available to the reader.
- `finishb`  in  1: one-cycle pulse from the reader when it is done with `bankb`.
- `frames_done`  out  16: count of banks released by the reader; wraps.
- `tlast_err`  out  1: sticky frame-length error (see Configuration).

## Operation
- Each bank carries one state bit: EMPTY or FULL.
- Reset:
  - Both banks EMPTY; `banka`=0, `bankb`=0.
  - Write counter `wcnt`=0.
  - Outputs `wea`, `readyb`, `tlast_err`, `frames_done`, `addra` and `dina` are all 0.
- Writer:
  - `s_axis_data_tready` = `rst` & (state[`banka`]==EMPTY); decoded from registers, with no combinational path from any input.
  - On each accepted beat (tvalid & tready): register `wea`=1, `addra`=`wcnt`, `dina`=tdata, then increment `wcnt`.
  - If no beat is accepted, the next cycle has `wea`=0.
  - When the beat at `wcnt`==MEMDEPTH-1 is accepted:
    - `wcnt`←0 and state[`banka`]←FULL.
    - `banka` toggles on the following edge, after the final `wea` cycle has been issued on the old `banka`.
- Reader:
  - `readyb` is registered: `readyb` ← (state[`bankb`]==FULL) & ~`finishb`.
  - `finishb` is honoured only while `readyb`==1. In that case:
    - state[`bankb`]←EMPTY, `bankb` toggles, and `frames_done` increments.
  - `finishb` arriving while `readyb`==0 is ignored.
- Ordering: banks fill 0,1,0,1… and are presented 0,1,0,1…, so frame order is preserved.
- Simultaneous events:
  - Completing a fill of bank X while `finishb` releases bank Y (X≠Y): both state updates apply in the same edge.
  - The writer may then immediately own Y; the reader sees X next.
- Backpressure: with both banks FULL, tready stays 0 until a `finishb` is honoured, and no data is dropped.
- Reset mid-frame: the partial frame is discarded, all state returns to reset values, and the next accepted beat goes to bank 0, address 0.

## Timing
- Write latency: accepted beat at edge N → `wea`/`addra`/`dina` valid in cycle N+1.
- Fill to present: last beat accepted at edge N → state FULL at N+1 → `readyb`=1 from cycle N+2 (if that bank is `bankb`).
- Release:
  - `finishb` sampled at edge N → `readyb`=0 in cycle N+1, and `bankb` has toggled in cycle N+1.
  - `readyb` can reassert no earlier than cycle N+2.
- Writer resume: if both banks are FULL and release happens at edge N, tready=1 in cycle N+1.
- Sustained throughput: 1 beat/cycle while the reader releases each bank within MEMDEPTH cycles of `readyb`.

## Configuration
- Macro `PPCTRL_TLAST_CHECK_EN`.
- Defined:
  - `tlast` is compared at every accepted beat.
  - `tlast` absent on the `wcnt`==MEMDEPTH-1 beat: `tlast_err`←1. The frame still completes normally.
  - `tlast`=1 on a beat with `wcnt`<MEMDEPTH-1:
    - `tlast_err`←1.
    - That beat is written.
    - `wcnt`←0 and the bank stays EMPTY: the partial frame is discarded and the next beat restarts the same bank at address 0.
  - `tlast_err` is sticky until reset.
- Undefined: `tlast` is ignored, frames are delimited by `wcnt` only, and `tlast_err` is tied to 0.

## Test plan
All cases use MEMDEPTH=8.
- Single frame:
  - Stimulus: 8 back-to-back beats 0..7 with tlast on beat 7; `finishb` held 0.
  - Required: `wea` on addresses 0..7 with `banka`=0; `readyb`=1 two cycles after the last beat; `bankb`=0.
- Both banks full:
  - Stimulus: 16 beats, reader idle.
  - Required: tready=0 after beat 16; beat 17 held off.
  - Then pulse `finishb`: `readyb`=0 the next cycle, `bankb`=1, tready=1, `frames_done`=1.
- Streaming:
  - Stimulus: 5 frames continuous; reader pulses `finishb` 10 cycles after each `readyb` rise.
  - Required: `bankb` sequence 0,1,0,1,0; `frames_done`=5; no tready drop on input beats 1..16.
- Simultaneous events:
  - Stimulus: `finishb` on the same edge that beat 8 of the other bank is accepted.
  - Required: both banks change state that edge; `readyb` low for exactly 1 cycle, then high with the new `bankb`.
- Reset mid-frame and spurious `finishb`:
  - Stimulus: `rst`=0 after 3 beats; then `finishb` with `readyb`=0.
  - Required: all outputs 0; `finishb` ignored (`frames_done`=0); the next beat lands at bank 0, address 0.
- With `PPCTRL_TLAST_CHECK_EN`:
  - Stimulus: tlast on beat 5, then 8 beats.
  - Required: `tlast_err`=1; bank 0 filled by the later 8 beats; `readyb` asserts once.

Source files
------------

// File: rtl/pingpong_bank_ctrl_if.sv
// Bundle for pingpong_bank_ctrl: AXI4-Stream input, port-A write side and the reader's bank handshake.
// slave is the bank controller's view; master is the surrounding stream source / memory / reader.
interface pingpong_bank_ctrl_if #(
    parameter int ADDRBITS = 7,
    parameter int DATABITS = 16
);
    logic [DATABITS-1:0] s_axis_data_tdata;
    logic                s_axis_data_tvalid;
    logic                s_axis_data_tready;
    logic                s_axis_data_tlast;
    logic [ADDRBITS-1:0] addra;
    logic [DATABITS-1:0] dina;
    logic                wea;
    logic                banka;
    logic                bankb;
    logic                readyb;
    logic                finishb;
    logic [15:0]         frames_done;
    logic                tlast_err;

    modport slave (
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, finishb,
        output s_axis_data_tready, addra, dina, wea, banka, bankb, readyb, frames_done, tlast_err
    );

    modport master (
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, finishb,
        input  s_axis_data_tready, addra, dina, wea, banka, bankb, readyb, frames_done, tlast_err
    );
endinterface

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong frame buffer manager: fills a free bank from the stream, presents full banks in order.
// Define PPCTRL_TLAST_CHECK_EN to check tlast against the frame length and raise the sticky tlast_err.
//
//   bank state | meaning
//   EMPTY      | bank may be claimed and written by the stream writer
//   FULL       | bank holds a complete frame, owned by the reader until finishb
module pingpong_bank_ctrl #(
    parameter int ADDRBITS = 7,
    parameter int DATABITS = 16,
    parameter int MEMDEPTH = 128
) (
    input logic                 clk,
    input logic                 rst,
    pingpong_bank_ctrl_if.slave bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

    localparam logic [ADDRBITS-1:0] LAST_ADDR = ADDRBITS'(MEMDEPTH - 1);

    bank_state_e         bank_state [2];
    logic                wbank;
    logic                banka_q;
    logic                bankb_q;
    logic [ADDRBITS-1:0] wcnt;
    logic [ADDRBITS-1:0] addra_q;
    logic [DATABITS-1:0] dina_q;
    logic                wea_q;
    logic                readyb_q;
    logic [15:0]         frames_done_q;

    logic tready;
    logic accept;
    logic last_beat;
    logic early_last;
    logic release_b;

    // wbank is the writer's bank and moves as soon as the last beat is taken, so the
    // stream never stalls between frames; banka trails it by one cycle to stay aligned with wea.
    always_comb begin
        tready     = rst & (bank_state[wbank] == EMPTY);
        accept     = tready & bus.s_axis_data_tvalid;
        last_beat  = accept & (wcnt == LAST_ADDR);
        release_b  = readyb_q & bus.finishb;
`ifdef PPCTRL_TLAST_CHECK_EN
        early_last = accept & bus.s_axis_data_tlast & (wcnt != LAST_ADDR);
`else
        early_last = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wbank         <= 1'b0;
            banka_q       <= 1'b0;
            bankb_q       <= 1'b0;
            wcnt          <= '0;
            addra_q       <= '0;
            dina_q        <= '0;
            wea_q         <= 1'b0;
            readyb_q      <= 1'b0;
            frames_done_q <= '0;
        end else begin
            wea_q   <= accept;
            banka_q <= wbank;
            if (accept) begin
                addra_q <= wcnt;
                dina_q  <= bus.s_axis_data_tdata;
            end

            if (last_beat) begin
                wcnt              <= '0;
                bank_state[wbank] <= FULL;
                wbank             <= ~wbank;
            end else if (early_last) begin
                wcnt <= '0;
            end else if (accept) begin
                wcnt <= wcnt + 1'b1;
            end

            // The writer only claims EMPTY banks and the reader only releases FULL ones,
            // so these two updates never target the same bank in one edge.
            if (release_b) begin
                bank_state[bankb_q] <= EMPTY;
                bankb_q             <= ~bankb_q;
                frames_done_q       <= frames_done_q + 16'd1;
            end

            readyb_q <= (bank_state[bankb_q] == FULL) & ~bus.finishb;
        end
    end

`ifdef PPCTRL_TLAST_CHECK_EN
    logic tlast_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tlast_err_q <= 1'b0;
        end else if ((last_beat & ~bus.s_axis_data_tlast) | early_last) begin
            tlast_err_q <= 1'b1;
        end
    end

    assign bus.tlast_err = tlast_err_q;
`else
    assign bus.tlast_err = 1'b0;
`endif

    assign bus.s_axis_data_tready = tready;
    assign bus.addra              = addra_q;
    assign bus.dina               = dina_q;
    assign bus.wea                = wea_q;
    assign bus.banka              = banka_q;
    assign bus.bankb              = bankb_q;
    assign bus.readyb             = readyb_q;
    assign bus.frames_done        = frames_done_q;

endmodule
